lc3_regfile: RTL and testbench

- LC-3 general-purpose register file (R0-R7) plus the NZP condition-code register.
- Two combinational read ports (SR1, SR2) sit directly upstream of the 16-bit operand/address selection muxes (SR2MUX, ADDR1MUX) and the ALU.
- One synchronous write port is loaded from the bus under LD_REG.
- Condition codes are computed from the same bus value under LD_CC.

---
 rtl/lc3_regfile.sv | 74 +++++++
 tb/tb_lc3_regfile.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/lc3_regfile.sv
// LC-3 register file: eight general-purpose registers with two combinational read
// ports and one synchronous write port, plus the NZP condition-code register.
module lc3_regfile #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              LD_REG,
   input  logic [ADDR_W-1:0] DR,
   input  logic [DATA_W-1:0] D_IN,
   input  logic              LD_CC,
   input  logic [ADDR_W-1:0] SR1,
   input  logic [ADDR_W-1:0] SR2,
   output logic [DATA_W-1:0] SR1_OUT,
   output logic [DATA_W-1:0] SR2_OUT,
   output logic              N,
   output logic              Z,
   output logic              P
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_r [NUM_REGS];
   logic [2:0]        nzp_r;
   logic [2:0]        nzp_next_s;

   // Two's-complement sign classification of a bus value as one-hot {N,Z,P}.
   function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] value);
      logic [2:0] cc;
      if (value[DATA_W-1]) begin
         cc = 3'b100;
      end else if (value == {DATA_W{1'b0}}) begin
         cc = 3'b010;
      end else begin
         cc = 3'b001;
      end
      return cc;
   endfunction

   // Next condition code: reloaded from the bus only when LD_CC is set.
   always_comb begin
      nzp_next_s = nzp_r;
      if (LD_CC) begin
         nzp_next_s = cc_of(D_IN);
      end else begin
         nzp_next_s = nzp_r;
      end
   end

   // Register array and NZP state; reset overrides both load enables.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
         nzp_r <= 3'b010;
      end else begin
         if (LD_REG) begin
            regs_r[DR] <= D_IN;
         end
         nzp_r <= nzp_next_s;
      end
   end

   // Reads have no write-through bypass: a write becomes visible after the edge.
   assign SR1_OUT = regs_r[SR1];
   assign SR2_OUT = regs_r[SR2];

   assign N = nzp_r[2];
   assign Z = nzp_r[1];
   assign P = nzp_r[0];

endmodule

// File: tb/tb_lc3_regfile.sv
// Directed-vector bench for lc3_regfile: reset, write/read sweep, no-bypass timing,
// condition codes, simultaneous loads and mid-sequence reset.
module tb_lc3_regfile;

   logic        CLK;
   logic        RST;
   logic        LD_REG;
   logic [2:0]  DR;
   logic [15:0] D_IN;
   logic        LD_CC;
   logic [2:0]  SR1;
   logic [2:0]  SR2;
   logic [15:0] SR1_OUT;
   logic [15:0] SR2_OUT;
   logic        N;
   logic        Z;
   logic        P;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_mem [8];

   lc3_regfile #(.DATA_W(16), .ADDR_W(3)) dut (
      .CLK(CLK), .RST(RST), .LD_REG(LD_REG), .DR(DR), .D_IN(D_IN), .LD_CC(LD_CC),
      .SR1(SR1), .SR2(SR2), .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT),
      .N(N), .Z(Z), .P(P)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then let inputs settle just after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_nzp(input string tag, input logic [2:0] exp);
      check(tag, {13'd0, N, Z, P}, {13'd0, exp});
   endtask

   // Read every register on both ports (opposite sweep orders) against the model.
   task automatic sweep(input string tag);
      for (int i = 0; i < 8; i++) begin
         SR1 = 3'(i);
         SR2 = 3'(7 - i);
         #1;
         check($sformatf("%s_sr1_r%0d", tag, i), SR1_OUT, exp_mem[i]);
         check($sformatf("%s_sr2_r%0d", tag, 7 - i), SR2_OUT, exp_mem[7 - i]);
      end
   endtask

   task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
      LD_REG = 1'b1;
      DR = idx;
      D_IN = val;
      tick();
      LD_REG = 1'b0;
      exp_mem[idx] = val;
   endtask

   task automatic load_cc(input string tag, input logic [15:0] val, input logic [2:0] exp);
      LD_CC = 1'b1;
      D_IN = val;
      tick();
      LD_CC = 1'b0;
      check_nzp(tag, exp);
   endtask

   initial begin
      RST = 1'b0; LD_REG = 1'b0; DR = 3'd0; D_IN = 16'h0000; LD_CC = 1'b0;
      SR1 = 3'd0; SR2 = 3'd0;
      #2;

      // Reset with competing loads: neither write may land.
      RST = 1'b1; LD_REG = 1'b1; DR = 3'd3; D_IN = 16'hFFFF; LD_CC = 1'b1;
      tick();
      RST = 1'b0; LD_REG = 1'b0; LD_CC = 1'b0;
      for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0000;
      check_nzp("reset_nzp", 3'b010);
      SR1 = 3'd3; SR2 = 3'd3;
      #1;
      check("reset_r3_sr1", SR1_OUT, 16'h0000);
      check("reset_r3_sr2", SR2_OUT, 16'h0000);
      sweep("reset");

      for (int i = 0; i < 8; i++) write_reg(3'(i), 16'(i) * 16'h1111);
      sweep("wr_all");

      // No bypass: old value before the edge, new one after.
      write_reg(3'd2, 16'h1234);
      LD_REG = 1'b1; DR = 3'd2; D_IN = 16'hABCD; SR1 = 3'd2; SR2 = 3'd2;
      #1;
      check("nobyp_sr1_before", SR1_OUT, 16'h1234);
      check("nobyp_sr2_before", SR2_OUT, 16'h1234);
      @(posedge CLK);
      #1;
      LD_REG = 1'b0;
      exp_mem[2] = 16'hABCD;
      check("nobyp_sr1_after", SR1_OUT, 16'hABCD);
      check("nobyp_sr2_after", SR2_OUT, 16'hABCD);

      load_cc("cc_8000", 16'h8000, 3'b100);
      load_cc("cc_0000", 16'h0000, 3'b010);
      load_cc("cc_7fff", 16'h7FFF, 3'b001);
      load_cc("cc_ffff", 16'hFFFF, 3'b100);
      D_IN = 16'h0000;
      tick();
      check_nzp("cc_hold", 3'b100);

      // Register write and CC load on the same edge from the same bus value.
      LD_REG = 1'b1; DR = 3'd5; D_IN = 16'h0000; LD_CC = 1'b1;
      tick();
      LD_REG = 1'b0; LD_CC = 1'b0;
      exp_mem[5] = 16'h0000;
      check_nzp("simul_nzp", 3'b010);
      sweep("simul");

      LD_REG = 1'b1; DR = 3'd1; D_IN = 16'h00FF; LD_CC = 1'b1;
      tick();
      LD_REG = 1'b0; LD_CC = 1'b0;
      exp_mem[1] = 16'h00FF;
      check_nzp("pre_rst_nzp", 3'b001);
      SR1 = 3'd1;
      #1;
      check("pre_rst_r1", SR1_OUT, 16'h00FF);

      RST = 1'b1; LD_REG = 1'b1; DR = 3'd1; D_IN = 16'h5555; LD_CC = 1'b1;
      tick();
      RST = 1'b0; LD_REG = 1'b0; LD_CC = 1'b0;
      for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0000;
      check_nzp("mid_rst_nzp", 3'b010);
      sweep("mid_rst");

      write_reg(3'd1, 16'h5555);
      SR1 = 3'd1; SR2 = 3'd0;
      #1;
      check("resume_r1", SR1_OUT, 16'h5555);
      check("resume_r0", SR2_OUT, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
